// File: rtl/tuner_sweep_peak_search.sv
// tuner_sweep_peak_search
//
// Sweeps the ring tuning DAC code from a start code towards an end code in
// fixed strides. Every step is a tune request to the control arbiter, a
// programmable settle wait, then one power sample from the power detector.
// A climb/fall detector with threshold and hysteresis picks out local maxima
// of the power-versus-code curve. Up to NUM_TARGET peaks, their count and an
// overflow flag are returned through a valid/ready result port.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-low reset
//   i_cfg_tune_*          sweep start / end / stride, latched at trigger accept
//   i_cfg_settle          idle cycles after each tune handshake
//   i_cfg_pwr_thresh      minimum power for a peak to be committed
//   i_cfg_pwr_hyst        hysteresis for peak commit and detector re-arm
//   i_trig_val/o_trig_rdy sweep start handshake
//   o_tune_*/i_tune_rdy   tune code request to the arbiter
//   i_pwr_*/o_pwr_rdy     power sample stream from the detector PHY
//   o_peaks_*/i_peaks_rdy sweep result (codes, powers, count, overflow)
//   o_mon_state           current FSM state
//   o_mon_peak_commit     one-cycle pulse per committed peak, dropped ones too
//
// state   | meaning
// IDLE    | waiting for a sweep trigger
// TUNE    | presenting the current code to the arbiter
// SETTLE  | settle down-counter running
// MEASURE | waiting for one power sample
// EVAL    | detector update, peak commit, next-code decision
// DONE    | presenting results until accepted

module tuner_sweep_peak_search #(
   parameter  int DAC_WIDTH    = 8,
   parameter  int ADC_WIDTH    = 8,
   parameter  int NUM_TARGET   = 4,
   parameter  int SETTLE_WIDTH = 8,
   localparam int CNT_W        = $clog2(NUM_TARGET + 1)
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [DAC_WIDTH-1:0]    i_cfg_tune_start,
   input  logic [DAC_WIDTH-1:0]    i_cfg_tune_end,
   input  logic [DAC_WIDTH-1:0]    i_cfg_tune_stride,
   input  logic [SETTLE_WIDTH-1:0] i_cfg_settle,
   input  logic [ADC_WIDTH-1:0]    i_cfg_pwr_thresh,
   input  logic [ADC_WIDTH-1:0]    i_cfg_pwr_hyst,
   input  logic                    i_trig_val,
   output logic                    o_trig_rdy,
   output logic                    o_tune_val,
   output logic [DAC_WIDTH-1:0]    o_tune_code,
   input  logic                    i_tune_rdy,
   input  logic                    i_pwr_val,
   input  logic [ADC_WIDTH-1:0]    i_pwr_data,
   output logic                    o_pwr_rdy,
   output logic                    o_peaks_val,
   input  logic                    i_peaks_rdy,
   output logic [DAC_WIDTH-1:0]    o_peaks_tune [NUM_TARGET],
   output logic [ADC_WIDTH-1:0]    o_peaks_pwr  [NUM_TARGET],
   output logic [CNT_W-1:0]        o_peaks_cnt,
   output logic                    o_peaks_ovf,
   output logic [2:0]              o_mon_state,
   output logic                    o_mon_peak_commit
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] TUNE    = 3'd1;
   localparam logic [2:0] SETTLE  = 3'd2;
   localparam logic [2:0] MEASURE = 3'd3;
   localparam logic [2:0] EVAL    = 3'd4;
   localparam logic [2:0] DONE    = 3'd5;

   logic [2:0]              state;
   logic [DAC_WIDTH-1:0]    code;
   logic [DAC_WIDTH-1:0]    cfg_end;
   logic [DAC_WIDTH-1:0]    stride;
   logic [SETTLE_WIDTH-1:0] settle_cnt;
   logic [ADC_WIDTH-1:0]    sample;

   // detector state
   logic                    climb;
   logic [ADC_WIDTH-1:0]    max_pwr;
   logic [DAC_WIDTH-1:0]    max_code;
   logic [ADC_WIDTH-1:0]    min_pwr;

   // EVAL-cycle combinational results
   logic                    nxt_climb;
   logic [ADC_WIDTH-1:0]    nxt_max;
   logic [DAC_WIDTH-1:0]    nxt_max_code;
   logic [ADC_WIDTH-1:0]    nxt_min;
   logic                    commit;
   logic [ADC_WIDTH-1:0]    commit_pwr;
   logic [DAC_WIDTH-1:0]    commit_code;
   logic [DAC_WIDTH:0]      next_code_wide;
   logic                    last_step;

   assign o_trig_rdy  = (state == IDLE) && i_rst;
   assign o_tune_val  = (state == TUNE);
   assign o_tune_code = code;
   assign o_pwr_rdy   = (state == MEASURE);
   assign o_peaks_val = (state == DONE);
   assign o_mon_state = state;

   always_comb begin
      nxt_climb    = climb;
      nxt_max      = max_pwr;
      nxt_max_code = max_code;
      nxt_min      = min_pwr;
      commit       = 1'b0;
      commit_pwr   = max_pwr;
      commit_code  = max_code;

      // one extra bit so a step past the top of the DAC range ends the sweep
      next_code_wide = {1'b0, code} + {1'b0, stride};
      last_step      = next_code_wide[DAC_WIDTH] ||
                       (next_code_wide > {1'b0, cfg_end});

      if (climb) begin
         if (sample > max_pwr) begin
            nxt_max      = sample;
            nxt_max_code = code;
         end else if ((({1'b0, sample} + {1'b0, i_cfg_pwr_hyst}) < {1'b0, max_pwr}) &&
                      (max_pwr >= i_cfg_pwr_thresh)) begin
            commit    = 1'b1;
            nxt_climb = 1'b0;
            nxt_min   = sample;
         end
      end else begin
         if (sample < min_pwr) begin
            nxt_min = sample;
         end
         if ({1'b0, sample} > ({1'b0, nxt_min} + {1'b0, i_cfg_pwr_hyst})) begin
            nxt_climb    = 1'b1;
            nxt_max      = sample;
            nxt_max_code = code;
         end
      end

      // A climb commit always leaves the detector falling, so a trailing
      // commit can never coincide with it in the same EVAL cycle.
      if (last_step && nxt_climb && (nxt_max >= i_cfg_pwr_thresh)) begin
         commit      = 1'b1;
         commit_pwr  = nxt_max;
         commit_code = nxt_max_code;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state             <= IDLE;
         code              <= '0;
         cfg_end           <= '0;
         stride            <= '0;
         settle_cnt        <= '0;
         sample            <= '0;
         climb             <= 1'b1;
         max_pwr           <= '0;
         max_code          <= '0;
         min_pwr           <= '0;
         o_peaks_cnt       <= '0;
         o_peaks_ovf       <= 1'b0;
         o_mon_peak_commit <= 1'b0;
         for (int i = 0; i < NUM_TARGET; i++) begin
            o_peaks_tune[i] <= '0;
            o_peaks_pwr[i]  <= '0;
         end
      end else begin
         o_mon_peak_commit <= 1'b0;
         case (state)
            IDLE: begin
               if (i_trig_val) begin
                  code        <= i_cfg_tune_start;
                  cfg_end     <= i_cfg_tune_end;
                  stride      <= (i_cfg_tune_stride == '0) ? DAC_WIDTH'(1) : i_cfg_tune_stride;
                  climb       <= 1'b1;
                  max_pwr     <= '0;
                  max_code    <= '0;
                  min_pwr     <= '0;
                  o_peaks_cnt <= '0;
                  o_peaks_ovf <= 1'b0;
                  for (int i = 0; i < NUM_TARGET; i++) begin
                     o_peaks_tune[i] <= '0;
                     o_peaks_pwr[i]  <= '0;
                  end
                  state <= TUNE;
               end
            end
            TUNE: begin
               if (i_tune_rdy) begin
                  settle_cnt <= i_cfg_settle;
                  state      <= SETTLE;
               end
            end
            SETTLE: begin
               if (settle_cnt == '0) begin
                  state <= MEASURE;
               end else begin
                  settle_cnt <= settle_cnt - SETTLE_WIDTH'(1);
               end
            end
            MEASURE: begin
               if (i_pwr_val) begin
                  sample <= i_pwr_data;
                  state  <= EVAL;
               end
            end
            EVAL: begin
               climb    <= nxt_climb;
               max_pwr  <= nxt_max;
               max_code <= nxt_max_code;
               min_pwr  <= nxt_min;
               if (commit) begin
                  o_mon_peak_commit <= 1'b1;
                  if (o_peaks_cnt < CNT_W'(NUM_TARGET)) begin
                     for (int i = 0; i < NUM_TARGET; i++) begin
                        if (o_peaks_cnt == CNT_W'(i)) begin
                           o_peaks_tune[i] <= commit_code;
                           o_peaks_pwr[i]  <= commit_pwr;
                        end
                     end
                     o_peaks_cnt <= o_peaks_cnt + CNT_W'(1);
                  end else begin
                     o_peaks_ovf <= 1'b1;
                  end
               end
               if (last_step) begin
                  state <= DONE;
               end else begin
                  code  <= next_code_wide[DAC_WIDTH-1:0];
                  state <= TUNE;
               end
            end
            DONE: begin
               if (i_peaks_rdy) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tuner_sweep_peak_search.sv
module tb_tuner_sweep_peak_search;

   localparam int NT = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] cfg_start, cfg_end, cfg_stride, cfg_settle, cfg_thresh, cfg_hyst;
   logic       trig_val, trig_rdy;
   logic       tune_val, tune_rdy;
   logic [7:0] tune_code;
   logic       pwr_val, pwr_rdy;
   logic [7:0] pwr_data;
   logic       peaks_val, peaks_rdy, peaks_ovf, peak_commit;
   logic [7:0] pk_tune [NT];
   logic [7:0] pk_pwr  [NT];
   logic [2:0] pk_cnt;
   logic [2:0] mon_state;

   always #5 clk = ~clk;

   tuner_sweep_peak_search dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_cfg_tune_start  (cfg_start),
      .i_cfg_tune_end    (cfg_end),
      .i_cfg_tune_stride (cfg_stride),
      .i_cfg_settle      (cfg_settle),
      .i_cfg_pwr_thresh  (cfg_thresh),
      .i_cfg_pwr_hyst    (cfg_hyst),
      .i_trig_val        (trig_val),
      .o_trig_rdy        (trig_rdy),
      .o_tune_val        (tune_val),
      .o_tune_code       (tune_code),
      .i_tune_rdy        (tune_rdy),
      .i_pwr_val         (pwr_val),
      .i_pwr_data        (pwr_data),
      .o_pwr_rdy         (pwr_rdy),
      .o_peaks_val       (peaks_val),
      .i_peaks_rdy       (peaks_rdy),
      .o_peaks_tune      (pk_tune),
      .o_peaks_pwr       (pk_pwr),
      .o_peaks_cnt       (pk_cnt),
      .o_peaks_ovf       (peaks_ovf),
      .o_mon_state       (mon_state),
      .o_mon_peak_commit (peak_commit)
   );

   int checks = 0;
   int errors = 0;

   // power-versus-code curve the bench's detector model answers from
   int tab [256];

   // reference model results
   int m_codes [$];
   int m_cnt, m_ovf, m_commits;
   int m_tune [NT];
   int m_pwr  [NT];

   // observations of the last sweep
   int hs_codes [$];
   int o_commits, o_cycles;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic add_peak(input int p, input int c);
      m_commits++;
      if (m_cnt < NT) begin
         m_tune[m_cnt] = c;
         m_pwr[m_cnt]  = p;
         m_cnt++;
      end else begin
         m_ovf = 1;
      end
   endtask

   // Builds the list of visited codes, then walks the power curve along it
   // looking for hysteresis-qualified local maxima.
   task automatic model(input int st, input int en, input int sd, input int th, input int hy);
      int step, c, s, mx, mxc, mn;
      bit rising;
      step = (sd == 0) ? 1 : sd;
      m_codes.delete();
      c = st;
      forever begin
         m_codes.push_back(c);
         if (c + step > en || c + step > 255) break;
         c = c + step;
      end
      m_cnt = 0; m_ovf = 0; m_commits = 0;
      for (int i = 0; i < NT; i++) begin
         m_tune[i] = 0;
         m_pwr[i]  = 0;
      end
      rising = 1; mx = 0; mxc = 0; mn = 0;
      foreach (m_codes[i]) begin
         s = tab[m_codes[i]];
         if (rising) begin
            if (s > mx) begin
               mx = s; mxc = m_codes[i];
            end else if (s + hy < mx && mx >= th) begin
               add_peak(mx, mxc);
               rising = 0; mn = s;
            end
         end else begin
            if (s < mn) mn = s;
            if (s > mn + hy) begin
               rising = 1; mx = s; mxc = m_codes[i];
            end
         end
      end
      if (rising && mx >= th) add_peak(mx, mxc);
   endtask

   task automatic compare(input string tag);
      chk({tag, "_cnt"}, int'(pk_cnt), m_cnt);
      chk({tag, "_ovf"}, int'(peaks_ovf), m_ovf);
      for (int i = 0; i < NT; i++) begin
         chk($sformatf("%s_tune%0d", tag, i), int'(pk_tune[i]), m_tune[i]);
         chk($sformatf("%s_pwr%0d", tag, i), int'(pk_pwr[i]), m_pwr[i]);
      end
      chk({tag, "_steps"}, hs_codes.size(), m_codes.size());
      foreach (m_codes[i]) begin
         if (i < hs_codes.size()) chk($sformatf("%s_code%0d", tag, i), hs_codes[i], m_codes[i]);
      end
      chk({tag, "_commits"}, o_commits, m_commits);
   endtask

   // Called at a negedge with the DUT idle. Leaves at a negedge in IDLE.
   task automatic run_sweep(input string tag, input int st, input int en, input int sd,
                            input int se, input int th, input int hy,
                            input bit stall, input int rdy_delay);
      int  k, cur, pend_code, snap_cnt, snap_t0, snap_p0;
      bit  pend, done;
      cfg_start = 8'(st); cfg_end = 8'(en); cfg_stride = 8'(sd);
      cfg_settle = 8'(se); cfg_thresh = 8'(th); cfg_hyst = 8'(hy);
      model(st, en, sd, th, hy);
      hs_codes.delete();
      o_commits = 0; cur = 0; pend = 0; pend_code = 0; done = 0;
      chk({tag, "_trig_rdy"}, int'(trig_rdy), 1);
      trig_val = 1'b1;
      @(negedge clk);
      trig_val = 1'b0;
      chk({tag, "_trig_to_tune"}, int'(tune_val), 1);
      for (k = 1; k <= 5000; k++) begin
         if (peak_commit) o_commits++;
         if (peaks_val) begin
            done = 1;
            break;
         end
         if (pend) begin
            chk({tag, "_tune_hold"}, int'(tune_val), 1);
            chk({tag, "_code_hold"}, int'(tune_code), pend_code);
         end
         tune_rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         pwr_val  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         pend = 0;
         if (tune_val && tune_rdy) begin
            hs_codes.push_back(int'(tune_code));
            cur = int'(tune_code);
         end else if (tune_val) begin
            pend = 1;
            pend_code = int'(tune_code);
         end
         // junk on the bus whenever the block is not asking for a sample
         pwr_data = pwr_rdy ? 8'(tab[cur]) : 8'($urandom);
         @(negedge clk);
      end
      tune_rdy = 1'b0;
      pwr_val  = 1'b0;
      o_cycles = k;
      chk({tag, "_done_reached"}, int'(done), 1);
      if (!stall) chk({tag, "_latency"}, o_cycles, m_codes.size() * (se + 4) + 1);
      compare(tag);
      snap_cnt = int'(pk_cnt); snap_t0 = int'(pk_tune[0]); snap_p0 = int'(pk_pwr[0]);
      for (int d = 0; d < rdy_delay; d++) begin
         @(negedge clk);
         chk({tag, "_val_hold"}, int'(peaks_val), 1);
         chk({tag, "_cnt_hold"}, int'(pk_cnt), snap_cnt);
         chk({tag, "_t0_hold"}, int'(pk_tune[0]), snap_t0);
         chk({tag, "_p0_hold"}, int'(pk_pwr[0]), snap_p0);
      end
      peaks_rdy = 1'b1;
      @(negedge clk);
      peaks_rdy = 1'b0;
      chk({tag, "_back_idle"}, int'(trig_rdy), 1);
      chk({tag, "_val_low"}, int'(peaks_val), 0);
      chk({tag, "_cnt_after"}, int'(pk_cnt), m_cnt);
   endtask

   initial begin
      int st, en, sd, se, th, hy;
      rst = 1'b0;
      cfg_start = '0; cfg_end = '0; cfg_stride = '0; cfg_settle = '0;
      cfg_thresh = '0; cfg_hyst = '0;
      trig_val = 1'b0; tune_rdy = 1'b0; pwr_val = 1'b0; pwr_data = '0; peaks_rdy = 1'b0;

      // reset
      repeat (3) @(negedge clk);
      chk("rst_trig_rdy", int'(trig_rdy), 0);
      chk("rst_state", int'(mon_state), 0);
      chk("rst_tune_val", int'(tune_val), 0);
      chk("rst_pwr_rdy", int'(pwr_rdy), 0);
      chk("rst_peaks_val", int'(peaks_val), 0);
      chk("rst_cnt", int'(pk_cnt), 0);
      chk("rst_ovf", int'(peaks_ovf), 0);
      chk("rst_commit", int'(peak_commit), 0);
      rst = 1'b1;
      @(negedge clk);
      chk("rel_trig_rdy", int'(trig_rdy), 1);

      // single peak at code 10
      for (int c = 0; c < 256; c++) tab[c] = (c <= 10) ? c * 10 : ((c <= 22) ? 100 - (c - 10) * 8 : 4);
      run_sweep("single", 0, 20, 1, 2, 10, 5, 0, 0);
      chk("single_cnt_k", int'(pk_cnt), 1);
      chk("single_tune_k", int'(pk_tune[0]), 10);
      chk("single_pwr_k", int'(pk_pwr[0]), 100);
      chk("single_steps_k", hs_codes.size(), 21);

      // hysteresis: 57 dip must not commit, peak at the 61 sample
      tab[0] = 50; tab[1] = 60; tab[2] = 57; tab[3] = 61; tab[4] = 40;
      run_sweep("hyst", 0, 4, 1, 0, 10, 5, 0, 0);
      chk("hyst_cnt_k", int'(pk_cnt), 1);
      chk("hyst_tune_k", int'(pk_tune[0]), 3);
      chk("hyst_pwr_k", int'(pk_pwr[0]), 61);

      // six separated peaks into four slots
      for (int c = 0; c < 256; c++) tab[c] = (c % 6 == 3) ? 200 : 20;
      run_sweep("ovf", 0, 35, 1, 1, 10, 5, 0, 0);
      chk("ovf_cnt_k", int'(pk_cnt), 4);
      chk("ovf_flag_k", int'(peaks_ovf), 1);
      chk("ovf_commits_k", o_commits, 6);
      chk("ovf_slot3_k", int'(pk_tune[3]), 21);

      // trailing peak at top of DAC range, stride 0 treated as 1 elsewhere
      for (int c = 0; c < 256; c++) tab[c] = c / 2;
      run_sweep("trail", 250, 255, 4, 1, 10, 5, 0, 0);
      chk("trail_steps_k", hs_codes.size(), 2);
      chk("trail_tune_k", int'(pk_tune[0]), 254);
      chk("trail_pwr_k", int'(pk_pwr[0]), 127);
      run_sweep("trail_hi", 250, 255, 4, 1, 200, 5, 0, 0);
      chk("trail_hi_cnt_k", int'(pk_cnt), 0);
      run_sweep("rev", 30, 20, 1, 0, 10, 5, 0, 0);
      chk("rev_steps_k", hs_codes.size(), 1);
      run_sweep("stride0", 10, 14, 0, 0, 3, 1, 0, 0);
      chk("stride0_steps_k", hs_codes.size(), 5);

      // random curves, stalled and unstalled
      for (int r = 0; r < 6; r++) begin
         for (int c = 0; c < 256; c++) tab[c] = int'($urandom_range(0, 255));
         st = int'($urandom_range(0, 220));
         en = st + int'($urandom_range(0, 40));
         if (en > 255) en = 255;
         sd = int'($urandom_range(0, 3));
         se = int'($urandom_range(0, 3));
         th = int'($urandom_range(0, 120));
         hy = int'($urandom_range(0, 30));
         run_sweep($sformatf("rnd%0d_stall", r), st, en, sd, se, th, hy, 1, 10);
         run_sweep($sformatf("rnd%0d_free", r), st, en, sd, se, th, hy, 0, 0);
      end

      // reset while waiting for a sample
      for (int c = 0; c < 256; c++) tab[c] = (c % 6 == 3) ? 200 : 20;
      cfg_start = 8'd0; cfg_end = 8'd35; cfg_stride = 8'd1; cfg_settle = 8'd1;
      cfg_thresh = 8'd10; cfg_hyst = 8'd5;
      trig_val = 1'b1;
      @(negedge clk);
      trig_val = 1'b0;
      tune_rdy = 1'b1;
      pwr_val  = 1'b0;
      for (int k = 0; k < 50 && !pwr_rdy; k++) @(negedge clk);
      chk("mrst_reached_measure", int'(mon_state), 3);
      rst = 1'b0;
      tune_rdy = 1'b0;
      @(negedge clk);
      chk("mrst_state", int'(mon_state), 0);
      chk("mrst_trig_rdy", int'(trig_rdy), 0);
      chk("mrst_tune_val", int'(tune_val), 0);
      chk("mrst_pwr_rdy", int'(pwr_rdy), 0);
      chk("mrst_peaks_val", int'(peaks_val), 0);
      chk("mrst_commit", int'(peak_commit), 0);
      chk("mrst_cnt", int'(pk_cnt), 0);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_trig_rdy_rel", int'(trig_rdy), 1);
      run_sweep("after_rst", 0, 35, 1, 1, 10, 5, 0, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/tuner_sweep_peak_search.md
# tuner_sweep_peak_search

Parametrised successor to the single-mode drop-port search engine. It sweeps the ring tuning DAC code over a programmable range, waits a programmable settle time after each step, and consumes one power sample per step from the power detector. It detects local maxima with a programmable threshold and hysteresis, and returns up to NUM_TARGET peaks plus count and overflow through a valid/ready result port. It sits between the power-detect PHY (sample stream) and the control arbiter (tune-code stream).

## Interface
- DAC_WIDTH, 8, tune code width
- ADC_WIDTH, 8, power sample width
- NUM_TARGET, 4, peak slots (≥1)
- SETTLE_WIDTH, 8, settle counter width
- CNT_W (localparam), $clog2(NUM_TARGET+1), peak count width
- i_clk  in  1  clock; all state updates on its rising edge
- i_rst  in  1  reset; synchronous, active-low
- i_cfg_tune_start / i_cfg_tune_end / i_cfg_tune_stride  in  DAC_WIDTH each  sweep range and step; sampled only at trigger accept
- i_cfg_settle  in  SETTLE_WIDTH  idle cycles after each tune handshake
- i_cfg_pwr_thresh  in  ADC_WIDTH  minimum peak power
- i_cfg_pwr_hyst  in  ADC_WIDTH  hysteresis for peak commit and re-arm
- i_trig_val  in  1  / o_trig_rdy  out  1  sweep start handshake
- o_tune_val  out  1  / o_tune_code  out  DAC_WIDTH  / i_tune_rdy  in  1  tune request to arbiter
- i_pwr_val  in  1  / i_pwr_data  in  ADC_WIDTH  / o_pwr_rdy  out  1  power sample
- o_peaks_val  out  1  / i_peaks_rdy  in  1  result handshake
- o_peaks_tune[NUM_TARGET]  out  DAC_WIDTH  peak codes, slot 0 = first found
- o_peaks_pwr[NUM_TARGET]  out  ADC_WIDTH  peak powers
- o_peaks_cnt  out  CNT_W  valid slots
- o_peaks_ovf  out  1  peaks found beyond NUM_TARGET were dropped
- o_mon_state  out  3  FSM state encoding
- o_mon_peak_commit  out  1  one-cycle pulse per committed peak (including dropped ones)

## Operation
- FSM states: IDLE, TUNE, SETTLE, MEASURE, EVAL, DONE.
- IDLE:
  - o_trig_rdy=1.
  - On i_trig_val&&o_trig_rdy: latch config, code=start, clear peak slots/cnt/ovf, set detector to CLIMB with max=0, go TUNE.
  - A stride of 0 is treated as 1.
- TUNE: o_tune_val=1, o_tune_code=code; on i_tune_rdy load settle counter with i_cfg_settle, go SETTLE.
- SETTLE: decrement each cycle; go MEASURE the cycle the counter is 0. A settle of 0 gives one SETTLE cycle.
- MEASURE: o_pwr_rdy=1; on i_pwr_val capture sample s, go EVAL. Samples offered outside MEASURE are not accepted.
- EVAL, CLIMB mode:
  - If s>max: max=s, max_code=code.
  - Else if s+hyst<max (ADC_WIDTH+1-bit compare) and max≥thresh: commit (max,max_code), switch to FALL with min=s.
- EVAL, FALL mode:
  - min=min(min,s).
  - If s>min+hyst (ADC_WIDTH+1-bit): switch to CLIMB with max=s, max_code=code.
- Commit: if cnt<NUM_TARGET, write the slot and increment cnt; else set ovf. Either way pulse o_mon_peak_commit.
- Next code: compute next=code+stride in DAC_WIDTH+1 bits.
  - If next>end or next overflows DAC_WIDTH: last step.
  - Otherwise code=next, go TUNE.
  - start>end gives exactly one step at start.
- Last step: if still in CLIMB and max≥thresh, commit a trailing peak in the same EVAL cycle, after the sample update. Go DONE.
- DONE: o_peaks_val=1, results stable; on i_peaks_rdy go IDLE. Results hold until the next trigger accept.

## Timing
- Reset (i_rst low at an edge): state IDLE, code=0, all slots/cnt/ovf 0, detector CLIMB/max=0.
  - o_tune_val, o_pwr_rdy, o_peaks_val and o_mon_peak_commit are 0.
  - o_trig_rdy is forced 0 while i_rst is low.
  - o_mon_state is 0 (IDLE).
- Reset mid-sweep aborts immediately; no partial result is presented.
- Trigger accept at edge N → o_tune_val=1 from cycle N+1.
- Per-step latency with i_tune_rdy and i_pwr_val held high is settle+4 cycles: TUNE 1, SETTLE settle+1, MEASURE 1, EVAL 1.
- Valid/ready: val never drops and its data never changes until the handshake completes. i_peaks_rdy is never required before o_peaks_val.
- Commit writes are visible on o_peaks_* the cycle after EVAL.

## Test plan
- Single peak: start=0, end=20, stride=1, settle=2, thresh=10, hyst=5, samples rise 0..100 at code 10 then fall → cnt=1, tune[0]=10, pwr[0]=100, ovf=0, 21 tune handshakes.
- Hysteresis: samples 50,60,57,61,40 with hyst=5, thresh=10 → only one peak, at the 61 sample. The 57 dip does not commit.
- Overflow: NUM_TARGET=4, six well-separated peaks → cnt=4, slots hold the first four, ovf=1, six commit pulses.
- Trailing edge and range wrap: start=250, end=255, stride=4, monotonic rise → two steps (250, 254), trailing peak at 254. Repeating with thresh above the max → cnt=0.
- Backpressure: i_tune_rdy and i_pwr_val randomly stalled, i_peaks_rdy delayed 10 cycles → identical results to the no-stall run, and outputs stable while val is high.
- Reset mid-MEASURE: pull i_rst low for one cycle → IDLE, all outputs at reset values, o_trig_rdy=1 the cycle after release, next sweep correct.
